// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle RV32 datapath (lw, sw, beq, R/I-type ALU).
// Optional performance counters are built when PERF_CNT_EN is defined.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_src,
  output logic [1:0] imm_sel,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_we,
  output logic       wb_sel,
  output logic       illegal
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("multicycle_ctrl: CNT_W must be at least 1");
  end

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_ADDR   = 4'd3,
    S_MEM_RD = 4'd4,
    S_MEM_WR = 4'd5,
    S_WB_ALU = 4'd6,
    S_WB_MEM = 4'd7,
    S_BRANCH = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;

  localparam logic [1:0] IMM_I    = 2'b00;
  localparam logic [1:0] IMM_S    = 2'b01;
  localparam logic [1:0] IMM_B    = 2'b10;
  localparam logic [1:0] IMM_NONE = 2'b11;

  state_t state_q, state_d;

  logic is_lw, is_sw, is_beq, is_rtype, is_itype;
  logic [1:0] imm_dec;

  assign is_lw    = (opcode == OP_LOAD)   && (funct3 == 3'b010);
  assign is_sw    = (opcode == OP_STORE)  && (funct3 == 3'b010);
  assign is_beq   = (opcode == OP_BRANCH) && (funct3 == 3'b000);
  assign is_rtype = (opcode == OP_RTYPE);
  assign is_itype = (opcode == OP_ITYPE);

  always_comb begin
    imm_dec = IMM_NONE;
    case (opcode)
      OP_LOAD, OP_ITYPE: imm_dec = IMM_I;
      OP_STORE:          imm_dec = IMM_S;
      OP_BRANCH:         imm_dec = IMM_B;
      default:           imm_dec = IMM_NONE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (is_lw || is_sw)            state_d = S_ADDR;
        else if (is_beq)               state_d = S_BRANCH;
        else if (is_rtype || is_itype) state_d = S_EXEC;
        else                           state_d = S_HALT;
      end
      S_ADDR:   state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (mem_ready) state_d = S_WB_MEM;
      S_MEM_WR: if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_WB_ALU;
      S_WB_ALU: state_d = S_FETCH;
      S_WB_MEM: state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Outputs are forced low while rst is high, so an in-flight access drops
  // its request immediately rather than at the next edge.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 1'b0;
    imm_sel   = IMM_NONE;
    alu_src_b = 2'b00;
    alu_op    = 2'b00;
    reg_we    = 1'b0;
    wb_sel    = 1'b0;
    illegal   = 1'b0;
    if (rst) begin
      imm_sel = 2'b00;
    end else begin
      case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          ir_we     = mem_ready;
          pc_we     = mem_ready;
        end
        S_DECODE: imm_sel = imm_dec;
        S_ADDR: begin
          alu_src_b = 2'b10;
          imm_sel   = (opcode == OP_LOAD) ? IMM_I : IMM_S;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
        end
        S_WB_MEM: begin
          reg_we = 1'b1;
          wb_sel = 1'b1;
        end
        S_EXEC: begin
          alu_op = 2'b10;
          if (is_itype) begin
            alu_src_b = 2'b10;
            imm_sel   = IMM_I;
          end
        end
        S_WB_ALU: reg_we = 1'b1;
        S_BRANCH: begin
          alu_op  = 2'b01;
          imm_sel = IMM_B;
          pc_src  = 1'b1;
          pc_we   = zero;
        end
        S_HALT: begin
          illegal = 1'b1;
          imm_sel = 2'b00;
        end
        default: begin
          illegal = 1'b1;
          imm_sel = 2'b00;
        end
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, instret_cnt_q;
  logic             retire;

  assign retire = (state_q == S_WB_MEM) || (state_q == S_WB_ALU) ||
                  (state_q == S_BRANCH) || ((state_q == S_MEM_WR) && mem_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (retire) instret_cnt_q <= instret_cnt_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule
